// File: rtl/freq_pkg.sv
// Shared types and helpers for the frequency BCD display path.
package freq_pkg;

    localparam int COUNT_W = 10;
    localparam int NDIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // BCD digit to active-low segments {g,f,e,d,c,b,a}; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
        logic [6:0] v_seg;
        case (i_digit)
            4'd0:    v_seg = 7'h40;
            4'd1:    v_seg = 7'h79;
            4'd2:    v_seg = 7'h24;
            4'd3:    v_seg = 7'h30;
            4'd4:    v_seg = 7'h19;
            4'd5:    v_seg = 7'h12;
            4'd6:    v_seg = 7'h02;
            4'd7:    v_seg = 7'h78;
            4'd8:    v_seg = 7'h00;
            4'd9:    v_seg = 7'h10;
            default: v_seg = 7'h7F;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/freq_bcd_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 iteration per clock.
module bin2bcd_seq #(
    parameter int BIN_W = freq_pkg::COUNT_W,
    parameter int DIG_N = freq_pkg::NDIGITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic [4*DIG_N-1:0] bcd,
    output logic               done
);
    import freq_pkg::*;

    localparam int BCD_W  = 4 * DIG_N;
    localparam int SR_W   = BCD_W + BIN_W;
    localparam int ITER_W = $clog2(BIN_W + 1);

    state_t            r_state;
    logic [SR_W-1:0]   r_sr;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy;
    logic [BCD_W-1:0]  r_bcd;
    logic              r_done;

    // Correct every BCD nibble that would overflow on doubling, then shift in the next binary bit.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] i_sr);
        logic [SR_W-1:0] v_sr;
        v_sr = i_sr;
        for (int d = 0; d < DIG_N; d++) begin
            if (v_sr[BIN_W + 4*d +: 4] >= 4'd5)
                v_sr[BIN_W + 4*d +: 4] = v_sr[BIN_W + 4*d +: 4] + 4'd3;
        end
        return {v_sr[SR_W-2:0], 1'b0};
    endfunction

    // Conversion FSM; busy/bcd/done are registered so the top sees clean strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr    <= {{BCD_W{1'b0}}, bin};
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr   <= dabble_step(r_sr);
                    r_iter <= r_iter + ITER_W'(1);
                    if (r_iter == ITER_W'(BIN_W - 1))
                        r_state <= DONE;
                end
                DONE: begin
                    r_bcd   <= r_sr[SR_W-1 -: BCD_W];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/freq_bcd_display.sv
// Converts each new window count to BCD and scans it onto a 4-digit common-anode display.
module freq_bcd_display #(
    parameter int COUNT_W  = freq_pkg::COUNT_W,
    parameter int NDIGITS  = freq_pkg::NDIGITS,
    parameter int SCAN_DIV = 48_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COUNT_W-1:0]   count_in,
    input  logic                 count_valid,
    output logic                 busy,
    output logic [4*NDIGITS-1:0] bcd,
    output logic                 bcd_valid,
    output logic [6:0]           seg,
    output logic [NDIGITS-1:0]   an
);
    import freq_pkg::*;

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic                 r_pend;
    logic [COUNT_W-1:0]   r_pend_val;
    logic [SCAN_W-1:0]    r_scan_cnt;
    logic [IDX_W-1:0]     r_dig_idx;
    logic [NDIGITS-1:0]   r_an;
    logic [6:0]           r_seg;

    logic                 w_busy;
    logic                 w_start;
    logic [COUNT_W-1:0]   w_bin;
    logic [4*NDIGITS-1:0] w_bcd;
    logic                 w_done;
    logic [NDIGITS-1:0]   w_blank;
    logic [3:0]           w_digit;
    logic [NDIGITS-1:0]   w_an_next;
    logic [6:0]           w_seg_next;

    // A live strobe is newer than anything parked, so it takes priority.
    assign w_start = !w_busy && (count_valid || r_pend);
    assign w_bin   = count_valid ? count_in : r_pend_val;

    bin2bcd_seq #(
        .BIN_W (COUNT_W),
        .DIG_N (NDIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (w_bin),
        .busy  (w_busy),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    // Pending flag: set by a strobe that arrives while converting, cleared when serviced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pend <= 1'b0;
        else if (count_valid && w_busy)
            r_pend <= 1'b1;
        else if (w_start)
            r_pend <= 1'b0;
    end

    // Pending value: only meaningful while r_pend is set, newest strobe overwrites.
    always_ff @(posedge clk) begin
        if (count_valid && w_busy)
            r_pend_val <= count_in;
    end

    // Leading-zero blanking: a digit is dark when it and every higher digit are zero.
    always_comb begin
        logic v_zero;
        w_blank = '0;
        v_zero  = 1'b1;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            v_zero     = v_zero && (w_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = v_zero;
        end
    end

    assign w_digit    = w_bcd[4*int'(r_dig_idx) +: 4];
    assign w_seg_next = w_blank[r_dig_idx] ? 7'h7F : seg_decode(w_digit);
    assign w_an_next  = ~(NDIGITS'(1) << r_dig_idx);

    // Digit scan: slot timer, digit index, and anode/segment drive registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_an       <= '1;
            r_seg      <= 7'h7F;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= (r_dig_idx == IDX_W'(NDIGITS - 1)) ? '0 : r_dig_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign busy      = w_busy;
    assign bcd       = w_bcd;
    assign bcd_valid = w_done;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed bench for freq_bcd_display with a shortened scan slot.
module tb_freq_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  count_in;
    logic        count_valid;
    logic        busy;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    freq_bcd_display #(
        .COUNT_W  (10),
        .NDIGITS  (4),
        .SCAN_DIV (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .busy        (busy),
        .bcd         (bcd),
        .bcd_valid   (bcd_valid),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one value from idle and wait (bounded) for its result.
    task automatic convert(input logic [9:0] v, input logic [15:0] exp, input string tag);
        int n;
        count_in    = v;
        count_valid = 1'b1;
        step();
        count_valid = 1'b0;
        n = 1;
        while (!bcd_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 12);
        chk(tag, bcd, exp);
    endtask

    initial begin
        int          pulses;
        int          run;
        logic [3:0]  prev_an;
        logic [15:0] got [2];
        int          at  [2];
        logic [6:0]  exp_seg;

        reset       = 1'b1;
        count_in    = '0;
        count_valid = 1'b0;

        // 1: reset held
        repeat (3) step();
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bcd_valid, 1'b0);
        reset = 1'b0;
        step();

        // 2: 987, busy for cycles 1..11, result at 12 only
        count_in    = 10'd987;
        count_valid = 1'b1;
        step();
        count_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("t2_busy_c%0d", c), busy, 1'b1);
            chk($sformatf("t2_valid_c%0d", c), bcd_valid, 1'b0);
            step();
        end
        chk("t2_valid_c12", bcd_valid, 1'b1);
        chk("t2_bcd_c12", bcd, 16'h0987);
        chk("t2_busy_c12", busy, 1'b0);
        step();
        chk("t2_valid_c13", bcd_valid, 1'b0);

        // 3: full scale and zero
        convert(10'd1023, 16'h1023, "t3_1023");
        step();
        convert(10'd0, 16'h0000, "t3_zero");
        repeat (2) step();
        for (int k = 0; k < 16; k++) begin
            exp_seg = (an == 4'b1110) ? 7'h40 : 7'h7F;
            chk($sformatf("t3_seg_an%b", an), seg, exp_seg);
            chk("t3_onehot", $countones(~an), 1);
            step();
        end

        // 4: 5 at cycle 0, 42 at cycle 4, 99 at cycle 6 -> 5 then 99
        pulses = 0;
        for (int c = 0; c <= 34; c++) begin
            count_valid = (c == 0 || c == 4 || c == 6);
            count_in    = (c == 0) ? 10'd5 : (c == 4) ? 10'd42 : 10'd99;
            if (bcd_valid) begin
                if (pulses < 2) begin
                    got[pulses] = bcd;
                    at[pulses]  = c;
                end
                pulses++;
            end
            step();
        end
        count_valid = 1'b0;
        chk("t4_pulses", pulses, 2);
        chk("t4_first_cycle", at[0], 12);
        chk("t4_first_bcd", got[0], 16'h0005);
        chk("t4_second_cycle", at[1], 24);
        chk("t4_second_bcd", got[1], 16'h0099);

        // 4b: strobe landing on the DONE cycle is kept as pending
        pulses = 0;
        for (int c = 0; c <= 30; c++) begin
            count_valid = (c == 0 || c == 11);
            count_in    = (c == 0) ? 10'd7 : 10'd8;
            if (bcd_valid) begin
                if (pulses < 2) begin
                    got[pulses] = bcd;
                    at[pulses]  = c;
                end
                pulses++;
            end
            step();
        end
        count_valid = 1'b0;
        chk("t4b_pulses", pulses, 2);
        chk("t4b_second_cycle", at[1], 24);
        chk("t4b_second_bcd", got[1], 16'h0008);

        // 5: 42 on the display, scan order, dwell and per-digit segments
        convert(10'd42, 16'h0042, "t5_42");
        repeat (2) step();
        prev_an = an;
        run     = 0;
        for (int k = 0; k < 40; k++) begin
            if (an !== prev_an) begin
                if (run > 0)
                    chk($sformatf("t5_dwell_an%b", prev_an), run, 4);
                chk("t5_order", an, {prev_an[2:0], prev_an[3]});
                run = 1;
            end else if (run > 0) begin
                run++;
            end
            if (k == 0 || an !== prev_an) begin
                if (k == 0) run = -100;
            end
            prev_an = an;
            exp_seg = (an == 4'b1110) ? 7'h24 : (an == 4'b1101) ? 7'h19 : 7'h7F;
            chk($sformatf("t5_seg_an%b", an), seg, exp_seg);
            chk("t5_onehot", $countones(~an), 1);
            step();
        end

        // 6: reset in the middle of a conversion
        count_in    = 10'd500;
        count_valid = 1'b1;
        step();
        count_valid = 1'b0;
        repeat (4) step();
        chk("t6_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_bcd", bcd, 16'h0000);
        chk("t6_valid", bcd_valid, 1'b0);
        chk("t6_an", an, 4'hF);
        chk("t6_seg", seg, 7'h7F);
        repeat (2) step();
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bcd_valid) pulses++;
        end
        chk("t6_no_valid", pulses, 0);
        chk("t6_idle", busy, 1'b0);
        convert(10'd321, 16'h0321, "t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
